// File: rtl/tick_period_checker_pkg.sv
// Shared timing definitions for the tick period checker: state encoding,
// default period/timeout values shared with the divider terminal counts,
// and a small saturating-increment helper.
package tick_period_checker_pkg;

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    ACQUIRE    = 2'd1,
    LOCKED     = 2'd2,
    LOST       = 2'd3
  } state_e;

  localparam int DEF_EXPECTED   = 5;
  localparam int DEF_TIMEOUT    = 16;
  localparam int DEF_LOCK_COUNT = 4;

  // 8-bit increment that holds at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/tick_period_checker_if.sv
// Tick input / checker status bundle. The master side drives the tick strobe
// and clear; the slave side (the checker) drives the measurement results.
interface tick_period_checker_if
  import tick_period_checker_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic             tick_in;
  logic             clear;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             timeout;
  logic             err;
  logic [7:0]       err_count;
  state_e           state;

  modport master (
    output tick_in, clear,
    input  period, period_valid, locked, timeout, err, err_count, state
  );

  modport slave (
    input  tick_in, clear,
    output period, period_valid, locked, timeout, err, err_count, state
  );
endinterface

// File: rtl/tick_interval_counter.sv
// Saturating interval counter: cleared on every tick (or restart), otherwise
// counts up and holds at all-ones. Flags the cycle in which cnt+1 reaches the
// timeout value.
module tick_interval_counter
  import tick_period_checker_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_zero,
  output logic [CNT_W-1:0] cnt,
  output logic             timeout_hit
);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [CNT_W:0]   cnt_inc;

  // Next count: load zero on tick, otherwise saturating increment.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d = cnt_q;
    if (load_zero) begin
      cnt_d = '0;
    end else if (!(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // Widened by one bit so the compare never wraps at saturation.
  assign cnt_inc     = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign timeout_hit = (cnt_inc == (CNT_W+1)'(TIMEOUT));
  assign cnt         = cnt_q;

endmodule

// File: rtl/tick_period_checker.sv
// Tick period checker: measures the interval between tick strobes, checks it
// against EXPECTED +/- TOL, locks after LOCK_COUNT consecutive good periods,
// and reports bad periods (sticky err, saturating err_count) and lost ticks.
module tick_period_checker
  import tick_period_checker_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int EXPECTED   = DEF_EXPECTED,
  parameter int TOL        = 0,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  tick_period_checker_if.slave bus
);

  localparam int             GOOD_W  = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W:0] EXP_EXT = (CNT_W+1)'(EXPECTED);
  localparam logic [CNT_W:0] TOL_EXT = (CNT_W+1)'(TOL);

  state_e            state_d, state_q;
  logic [CNT_W-1:0]  period_d, period_q;
  logic              pv_d, pv_q;
  logic              locked_d, locked_q;
  logic              timeout_d, timeout_q;
  logic              err_d, err_q;
  logic [7:0]        err_cnt_d, err_cnt_q;
  logic [GOOD_W-1:0] good_d, good_q;

  logic [CNT_W-1:0]  cnt;
  logic              timeout_hit;
  logic [CNT_W:0]    meas_ext;
  logic [CNT_W:0]    dev;
  logic              good;
  logic [GOOD_W-1:0] good_inc;

  // Clear also restarts the interval measurement.
  tick_interval_counter #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_zero  (bus.tick_in | bus.clear),
    .cnt        (cnt),
    .timeout_hit(timeout_hit)
  );

  // Period of the current tick and its absolute deviation from EXPECTED.
  always_comb begin
    meas_ext = {1'b0, cnt} + (CNT_W+1)'(1);
    dev      = (meas_ext >= EXP_EXT) ? meas_ext - EXP_EXT : EXP_EXT - meas_ext;
    good     = (dev <= TOL_EXT);
    good_inc = good_q + GOOD_W'(1);
  end

  // Next-state and statistics update; clear overrides any tick in the same cycle.
  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    pv_d      = 1'b0;
    timeout_d = timeout_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    good_d    = good_q;

    if (bus.clear) begin
      state_d   = WAIT_FIRST;
      period_d  = '0;
      timeout_d = 1'b0;
      err_d     = 1'b0;
      err_cnt_d = '0;
      good_d    = '0;
    end else begin
      unique case (state_q)
        WAIT_FIRST, LOST: begin
          if (bus.tick_in) begin
            state_d   = ACQUIRE;
            good_d    = '0;
            timeout_d = 1'b0;
          end
        end
        ACQUIRE: begin
          if (bus.tick_in) begin
            pv_d     = 1'b1;
            period_d = meas_ext[CNT_W-1:0];
            if (good) begin
              good_d = good_inc;
              if (good_inc == GOOD_W'(LOCK_COUNT)) state_d = LOCKED;
            end else begin
              good_d    = '0;
              err_d     = 1'b1;
              err_cnt_d = sat_inc8(err_cnt_q);
            end
          end else if (timeout_hit) begin
            state_d   = LOST;
            timeout_d = 1'b1;
            good_d    = '0;
          end
        end
        LOCKED: begin
          if (bus.tick_in) begin
            pv_d     = 1'b1;
            period_d = meas_ext[CNT_W-1:0];
            if (!good) begin
              state_d   = LOST;
              good_d    = '0;
              err_d     = 1'b1;
              err_cnt_d = sat_inc8(err_cnt_q);
            end
          end else if (timeout_hit) begin
            state_d   = LOST;
            timeout_d = 1'b1;
            good_d    = '0;
          end
        end
        default: state_d = WAIT_FIRST;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= WAIT_FIRST;
      period_q  <= '0;
      pv_q      <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      good_q    <= '0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      pv_q      <= pv_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      good_q    <= good_d;
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = pv_q;
  assign bus.locked       = locked_q;
  assign bus.timeout      = timeout_q;
  assign bus.err          = err_q;
  assign bus.err_count    = err_cnt_q;
  assign bus.state        = state_q;

endmodule
